// File: rtl/led_tick_gen.sv
// led_tick_gen: programmable rate generator feeding the LED sweep stage.
// Divides the system clock into a one-cycle tick strobe (clock enable) whose period is
// div_reg+1 cycles. The divisor can be reloaded at run time; a reload never shortens or
// stretches the period in progress while running. Also counts emitted ticks.
//
// Optional build macro: LED_TICK_SYNC_EN -- when defined, enable passes through a
// 2-flop synchronizer (reset to 0) before the FSM, adding 2 cycles of start/stop latency.
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous, active-high reset (priority over all inputs)
//   enable      in   1 = run, 0 = hold (counter frozen)
//   div_load    in   1-cycle strobe: capture div_value into the staging register
//   div_value   in   new divisor; period = div_value+1 cycles
//   tick        out  1-cycle strobe, one per period while running
//   tick_count  out  ticks emitted since reset, wraps
//   running     out  1 while the FSM is in RUN
//   div_pending out  1 while a loaded divisor awaits application
module led_tick_gen #(
  parameter int unsigned DIV_W       = 26,
  parameter int unsigned DEFAULT_DIV = 2499999,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             running,
  output logic             div_pending
);

  localparam logic [DIV_W-1:0] DefaultDiv = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_reg_q, div_reg_d;
  logic [DIV_W-1:0] div_stage_q, div_stage_d;
  logic             div_pending_q, div_pending_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;
  logic             running_q, running_d;
  logic             en_eff;

`ifdef LED_TICK_SYNC_EN
  logic [1:0] en_sync_q, en_sync_d;

  always_comb begin
    en_sync_d = {en_sync_q[0], enable};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_sync_q <= 2'b00;
    end else begin
      en_sync_q <= en_sync_d;
    end
  end

  assign en_eff = en_sync_q[1];
`else
  assign en_eff = enable;
`endif

  // Outside RUN a pending divisor is applied the cycle after it was loaded; a fresh
  // div_load in the same cycle defers that so the newest value wins.
  logic             apply_idle;
  logic [DIV_W-1:0] start_val;
  // At terminal count a same-cycle div_load is folded straight into the reload.
  logic             apply_tc;
  logic [DIV_W-1:0] tc_val;

  always_comb begin
    apply_idle = div_pending_q & ~div_load;
    start_val  = apply_idle ? div_stage_q : div_reg_q;
    apply_tc   = div_pending_q | div_load;
    tc_val     = div_load ? div_value : div_stage_q;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_reg_d     = div_reg_q;
    div_stage_d   = div_stage_q;
    div_pending_d = div_pending_q;
    tick_d        = 1'b0;
    tick_count_d  = tick_count_q;

    if (div_load) begin
      div_stage_d   = div_value;
      div_pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (apply_idle) begin
          div_reg_d     = div_stage_q;
          cnt_d         = div_stage_q;
          div_pending_d = 1'b0;
        end
        if (en_eff) begin
          state_d = StRun;
          cnt_d   = start_val;
        end
      end
      StHold: begin
        // A divisor applied while holding restarts a full period.
        if (apply_idle) begin
          div_reg_d     = div_stage_q;
          cnt_d         = div_stage_q;
          div_pending_d = 1'b0;
        end
        if (en_eff) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!en_eff) begin
          state_d = StHold;
        end else if (cnt_q == '0) begin
          tick_d       = 1'b1;
          tick_count_d = tick_count_q + CNT_W'(1);
          if (apply_tc) begin
            div_reg_d     = tc_val;
            cnt_d         = tc_val;
            div_pending_d = 1'b0;
          end else begin
            cnt_d = div_reg_q;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    running_d = (state_d == StRun);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= DefaultDiv;
      div_reg_q     <= DefaultDiv;
      div_stage_q   <= DefaultDiv;
      div_pending_q <= 1'b0;
      tick_q        <= 1'b0;
      tick_count_q  <= '0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_reg_q     <= div_reg_d;
      div_stage_q   <= div_stage_d;
      div_pending_q <= div_pending_d;
      tick_q        <= tick_d;
      tick_count_q  <= tick_count_d;
      running_q     <= running_d;
    end
  end

  assign tick        = tick_q;
  assign tick_count  = tick_count_q;
  assign running     = running_q;
  assign div_pending = div_pending_q;

endmodule

// File: tb/tb_led_tick_gen.sv
module tb_led_tick_gen;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 4;
`ifdef LED_TICK_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             tick;
  logic [CNT_W-1:0] tick_count;
  logic             running;
  logic             div_pending;

  int n_checks = 0;
  int n_fail   = 0;

  led_tick_gen #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(4),
    .CNT_W      (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .div_load   (div_load),
    .div_value  (div_value),
    .tick       (tick),
    .tick_count (tick_count),
    .running    (running),
    .div_pending(div_pending)
  );

  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    div_load  = 1'b0;
    div_value = '0;

    // Reset state, then default divisor 4 -> period 5.
    cyc(3);
    check("rst_tick", 32'(tick), 0);
    check("rst_count", 32'(tick_count), 0);
    check("rst_running", 32'(running), 0);
    check("rst_pending", 32'(div_pending), 0);
    reset  = 1'b0;
    enable = 1'b1;
    cyc(1 + L);
    check("t1_running", 32'(running), 1);
    cyc(4);
    check("t1_no_early_tick", 32'(tick), 0);
    cyc(1);
    check("t1_first_tick", 32'(tick), 1);
    check("t1_count1", 32'(tick_count), 1);
    cyc(1);
    check("t1_tick_single", 32'(tick), 0);
    cyc(3);
    check("t1_gap", 32'(tick), 0);
    cyc(1);
    check("t1_second_tick", 32'(tick), 1);
    cyc(10);
    check("t1_fourth_tick", 32'(tick), 1);
    check("t1_count4", 32'(tick_count), 4);

    // Reset mid-period with a divisor pending: pending discarded, default divisor back.
    div_value = 8'd7;
    div_load  = 1'b1;
    cyc(1);
    check("t6_pending", 32'(div_pending), 1);
    div_load = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    check("t6_tick", 32'(tick), 0);
    check("t6_count", 32'(tick_count), 0);
    check("t6_running", 32'(running), 0);
    check("t6_pending_clr", 32'(div_pending), 0);
    reset = 1'b0;
    cyc(1 + L);
    check("t6_running_again", 32'(running), 1);
    cyc(4);
    check("t6_no_early_tick", 32'(tick), 0);
    cyc(1);
    check("t6_default_period", 32'(tick), 1);
    check("t6_count1", 32'(tick_count), 1);

    // Hold at cnt==2 for 7 cycles, then resume (not restart).
    cyc(2);
    enable = 1'b0;
    cyc(1 + L);
    check("t4_running_low", 32'(running), 0);
    check("t4_no_tick_fall", 32'(tick), 0);
    for (int i = 0; i < 6 - L; i++) begin
      cyc(1);
      check("t4_hold_no_tick", 32'(tick), 0);
    end
    enable = 1'b1;
    cyc(1 + L);
    check("t4_running_high", 32'(running), 1);
    cyc(2 - L);
    check("t4_resume_no_tick", 32'(tick), 0);
    cyc(1);
    check("t4_resume_tick", 32'(tick), 1);
    check("t4_count2", 32'(tick_count), 2);

    // Reload to 9 at cnt==2: old period finishes, then 10-cycle periods.
    cyc(2);
    div_value = 8'd9;
    div_load  = 1'b1;
    cyc(1);
    check("t3_pending_set", 32'(div_pending), 1);
    check("t3_tick0", 32'(tick), 0);
    div_load = 1'b0;
    cyc(1);
    check("t3_pending_hold", 32'(div_pending), 1);
    check("t3_tick1", 32'(tick), 0);
    cyc(1);
    check("t3_old_rate_tick", 32'(tick), 1);
    check("t3_pending_clr", 32'(div_pending), 0);
    check("t3_count3", 32'(tick_count), 3);
    cyc(9);
    check("t3_new_gap", 32'(tick), 0);
    cyc(1);
    check("t3_new_rate_tick", 32'(tick), 1);
    check("t3_count4", 32'(tick_count), 4);

    // div_value=0 loaded in IDLE: tick every cycle, tick_count wraps at 16.
    reset  = 1'b1;
    enable = 1'b0;
    cyc(1);
    reset     = 1'b0;
    div_value = 8'd0;
    div_load  = 1'b1;
    cyc(1);
    check("t2_pending_idle", 32'(div_pending), 1);
    check("t2_idle_running", 32'(running), 0);
    div_load = 1'b0;
    enable   = 1'b1;
    cyc(1);
    check("t2_applied", 32'(div_pending), 0);
    cyc(L);
    check("t2_running", 32'(running), 1);
    check("t2_tick_start", 32'(tick), 0);
    for (int i = 0; i < 17; i++) begin
      cyc(1);
      check("t2_continuous", 32'(tick), 1);
      check("t2_count", 32'(tick_count), 32'((i + 1) % 16));
    end
    check("t5_wrapped", 32'(tick_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
